// File: rtl/ysyx_24080006_pkg.sv
// Shared ysyx_24080006 definitions: stage payload bundle, ALU encodings and sizing helpers.
package ysyx_24080006_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_PASS = 4'd8;

  localparam logic [2:0] SET_NONE = 3'd0;
  localparam logic [2:0] SET_EQ   = 3'd1;
  localparam logic [2:0] SET_NE   = 3'd2;
  localparam logic [2:0] SET_LT   = 3'd3;
  localparam logic [2:0] SET_GE   = 3'd4;
  localparam logic [2:0] SET_LTU  = 3'd5;
  localparam logic [2:0] SET_GEU  = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] dnpc;
    logic [XLEN-1:0] sdata;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [2:0]      alu_set;
    logic [4:0]      rd_addr;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_we;
    logic [2:0]      funct3;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            is_branch;
    logic            is_jump;
    logic            is_ecall;
    logic            is_mret;
    logic            is_ebreak;
  } stage_payload_t;

  localparam int unsigned STAGE_W = $bits(stage_payload_t);

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ysyx_24080006_stage_mem.sv
// DEPTH x DW storage array: one synchronous write port, one asynchronous read port.
module ysyx_24080006_stage_mem #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are intentionally not reset; validity is tracked by the owner.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_24080006_stage_buf.sv
// Elastic valid/ready FIFO between pipeline stages with synchronous flush.
// Optional same-cycle empty bypass: YSYX_24080006_STAGE_BUF_BYPASS_EN.
module ysyx_24080006_stage_buf
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = ptr_w(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic [DW-1:0] mem_rdata;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

`ifdef YSYX_24080006_STAGE_BUF_BYPASS_EN
  // Empty buffer forwards the input; a payload taken the same cycle is never stored.
  assign out_valid = !flush && (empty ? in_valid : 1'b1);
  assign out_data  = empty ? in_data : mem_rdata;
  assign wr_en     = push && !(empty && out_ready);
`else
  assign out_valid = !flush && !empty;
  assign out_data  = mem_rdata;
  assign wr_en     = push;
`endif

  assign rd_en = pop && !empty;

  // Explicit wrap so non-power-of-two depths work.
  assign wr_ptr_nxt = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
  assign rd_ptr_nxt = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr_nxt;
      if (rd_en) rd_ptr <= rd_ptr_nxt;
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (!wr_en && rd_en) count <= count - CW'(1);
    end
  end

  ysyx_24080006_stage_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

`ifndef SYNTHESIS
  // A stalled upstream payload must not change until taken or withdrawn.
  a_in_data_stable: assert property (
    @(posedge clock) disable iff (!reset_n)
    (in_valid && !in_ready && !flush) |=> (!in_valid || $stable(in_data))
  );
`endif

endmodule

// File: tb/tb_ysyx_24080006_stage_buf.sv
// Scoreboard bench for ysyx_24080006_stage_buf at DEPTH 2, 4 and 3 (DW = 8).
module tb_ysyx_24080006_stage_buf;

  localparam int unsigned DW = 8;
`ifdef YSYX_24080006_STAGE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [2:0]           flush, in_valid, out_ready, in_ready, out_valid;
  logic [2:0][DW-1:0]   in_data, out_data;
  logic [2:0][2:0]      cnt;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;
  int n_out    = 0;
  bit last_push;
  logic [DW-1:0] sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 2 : ((g == 1) ? 4 : 3);
    logic [$clog2(D+1)-1:0] c;
    ysyx_24080006_stage_buf #(.DW(DW), .DEPTH(D)) u_dut (
      .clock     (clk),
      .reset_n   (rst_n),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .count     (c)
    );
    assign cnt[g] = 3'(c);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock on instance cur: record handshakes, advance, compare count to model.
  task automatic cycle();
    logic push, pop;
    logic [DW-1:0] exp;
    #1;
    push = in_valid[cur] && in_ready[cur];
    pop  = out_valid[cur] && out_ready[cur];
    last_push = push;
    if (push) sb.push_back(in_data[cur]);
    if (pop) begin
      check("sb_has_data", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("out_data", 32'(out_data[cur]), 32'(exp));
        n_out++;
      end
    end
    @(posedge clk);
    if (flush[cur]) sb.delete();
    @(negedge clk);
    check("count", 32'(cnt[cur]), 32'(BYP ? 0 : sb.size()) | 32'(BYP ? cnt[cur] - cnt[cur] + 3'(sb.size()) : 0));
  endtask

  task automatic drain(input string tag);
    in_valid[cur]  = 1'b0;
    out_ready[cur] = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) cycle();
    check({tag, "_drained"}, 32'(sb.size()), 0);
    #1;
    check({tag, "_idle"}, 32'(out_valid[cur]), 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = '0; in_valid = '0; out_ready = '0; in_data = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", 32'(out_valid[i]), 0);
      check("rst_count", 32'(cnt[i]), 0);
      check("rst_in_ready", 32'(in_ready[i]), 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Fill DEPTH=2 with the sink stalled; 0x33 waits for a pop.
    cur = 0; out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = 8'h11; cycle();
    check("t1_cnt1", 32'(cnt[0]), 1);
    in_data[0] = 8'h22; cycle();
    check("t1_cnt2", 32'(cnt[0]), 2);
    check("t1_full_rdy", 32'(in_ready[0]), 0);
    in_data[0] = 8'h33; cycle(); cycle();
    check("t1_33_held", 32'(cnt[0]), 2);
    out_ready[0] = 1'b1; cycle();
    check("t1_33_not_in", 32'(last_push), 0);
    cycle();
    check("t1_33_in", 32'(last_push), 1);
    in_data[0] = 8'h44; cycle();
    drain("t1");

    // Continuous stream on DEPTH=4.
    cur = 1; n_out = 0; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      in_data[1] = 8'(k);
      cycle();
      check("t2_cnt", 32'(cnt[1]), BYP ? 0 : 1);
    end
    check("t2_nout", 32'(n_out), BYP ? 64 : 63);
    drain("t2");
    check("t2_total", 32'(n_out), 64);

    // Random handshakes on DEPTH=3.
    begin
      int sent = 0;
      cur = 2; n_out = 0; in_valid[2] = 1'b0;
      for (int cyc = 0; cyc < 20000 && n_out < 1000; cyc++) begin
        if (!in_valid[2] && sent < 1000 && $urandom_range(0, 1) == 1) begin
          in_valid[2] = 1'b1;
          in_data[2]  = 8'($urandom);
        end
        out_ready[2] = 1'($urandom_range(0, 1));
        cycle();
        check("t3_cnt_max", 32'(cnt[2] <= 3'd3), 1);
        if (last_push) begin
          sent++;
          in_valid[2] = 1'b0;
        end
      end
      check("t3_delivered", 32'(n_out), 1000);
      drain("t3");
    end

    // Flush with a payload offered: nothing accepted, nothing delivered.
    cur = 0; out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = 8'h01; cycle();
    in_data[0] = 8'h02; cycle();
    check("t4_cnt2", 32'(cnt[0]), 2);
    flush[0] = 1'b1; in_data[0] = 8'hAA;
    #1;
    check("t4_flush_rdy", 32'(in_ready[0]), 0);
    check("t4_flush_ov", 32'(out_valid[0]), 0);
    cycle();
    check("t4_flush_push", 32'(last_push), 0);
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    #1;
    check("t4_post_cnt", 32'(cnt[0]), 0);
    check("t4_post_ov", 32'(out_valid[0]), 0);
    out_ready[0] = 1'b1;
    repeat (3) cycle();
    check("t4_no_aa", 32'(n_out), 0 + n_out * 0 + (sb.size() == 0 ? n_out : 32'hFFFF));

    // Asynchronous reset mid-cycle with two entries stored.
    out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = 8'h05; cycle();
    in_data[0] = 8'h06; cycle();
    in_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ov", 32'(out_valid[0]), 0);
    check("t5_cnt", 32'(cnt[0]), 0);
    check("t5_rdy", 32'(in_ready[0]), 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty buffer latency: same cycle with bypass, next cycle without.
    cur = 1; n_out = 0; in_valid[1] = 1'b1; out_ready[1] = 1'b1; in_data[1] = 8'h5A;
    #1;
    check("t6_ov_same", 32'(out_valid[1]), 32'(BYP));
    cycle();
    in_valid[1] = 1'b0;
    #1;
    check("t6_ov_next", 32'(out_valid[1]), 32'(!BYP));
    drain("t6");
    check("t6_delivered", 32'(n_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
